alu_md_unit: RTL and testbench

- Parametrised, handshaked successor to the single-cycle execute ALU.
- Performs the base integer/branch-compare operations with a registered one-cycle result.
- Adds RV M-extension multiply/divide/remainder through an internal iterative datapath.
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid and flushes on redirect.

---
 rtl/alu_md_unit_if.sv | 26 ++
 rtl/alu_md_unit.sv | 200 ++++++++++++++++++++
 tb/tb_alu_md_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_md_unit_if.sv
// Request/response bundle between the EX-stage pipeline and alu_md_unit.
// The pipeline side is the master; the execute unit is the slave.
interface alu_md_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            br_mark;
    logic            busy;

    modport master (
        output in_valid, alu_op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, br_mark, busy
    );

    modport slave (
        input  in_valid, alu_op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, br_mark, busy
    );
endinterface

// File: rtl/alu_md_unit.sv
// Handshaked EX-stage ALU: single-cycle base/compare ops plus M-extension
// multiply (iterative or single-cycle) and radix-2 restoring divide.
module alu_md_unit #(
    parameter int unsigned XLEN     = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    alu_md_unit_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN);

    localparam logic [4:0] OP_AND  = 5'd0,  OP_OR    = 5'd1,  OP_ADD  = 5'd2,  OP_SUB  = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4,  OP_SLT   = 5'd5,  OP_SLTU = 5'd6,  OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8,  OP_SRA   = 5'd9,  OP_JUMP = 5'd10, OP_NOTEQ = 5'd11;
    localparam logic [4:0] OP_SGE  = 5'd12, OP_SGEU  = 5'd13;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [XLEN-1:0]     res_q;
    logic                br_q;
    logic [2*XLEN-1:0]   acc, mcand;
    logic [XLEN-1:0]     mplier, rem, quot, dvs;
    logic                neg_q, neg_r, sel_hi;

    logic [4:0]          op;
    logic [XLEN-1:0]     a, b;
    logic [SHW-1:0]      shamt;
    logic                accept;

    assign op     = bus.alu_op;
    assign a      = bus.op_a;
    assign b      = bus.op_b;
    assign shamt  = b[SHW-1:0];
    assign accept = bus.in_valid & bus.in_ready;

    logic [XLEN-1:0] base_res;
    logic            base_br;

    always_comb begin
        base_res = '0;
        case (op)
            OP_AND:            base_res = a & b;
            OP_OR:             base_res = a | b;
            OP_ADD, OP_JUMP:   base_res = a + b;
            OP_SUB, OP_NOTEQ:  base_res = a - b;
            OP_XOR:            base_res = a ^ b;
            OP_SLT, OP_SGE:    base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU, OP_SGEU:  base_res = {{(XLEN-1){1'b0}}, a < b};
            OP_SLL:            base_res = a << shamt;
            OP_SRL:            base_res = a >> shamt;
            OP_SRA:            base_res = $signed(a) >>> shamt;
            default:           base_res = '0;
        endcase
        base_br = 1'b0;
        case (op)
            OP_JUMP:                   base_br = 1'b1;
            OP_NOTEQ, OP_SLT, OP_SLTU: base_br = |base_res;
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
            OP_SGE, OP_SGEU:           base_br = ~|base_res;
            default:                   base_br = 1'b0;
        endcase
    end

    // M ops: op[2] selects divide; op[1:0] carries signedness and hi/rem select.
    logic            is_m, is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [2*XLEN-1:0] ax, bx, fprod;

    assign is_m     = (op[4:3] == 2'b10);
    assign is_mul   = is_m & ~op[2];
    assign is_div   = is_m & op[2];
    assign a_sgn    = is_mul ? (op[1:0] != 2'b11) : ~op[0];
    assign b_sgn    = is_mul ? ~op[1] : ~op[0];
    assign a_neg    = a_sgn & a[XLEN-1];
    assign b_neg    = b_sgn & b[XLEN-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = (b == '0);
    assign div_ovf  = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign ax       = {{XLEN{a_neg}}, a};
    assign bx       = {{XLEN{b_neg}}, b};
    assign fprod    = ax * bx;
    assign fast_res = (op[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];

    logic [XLEN-1:0] imm_res;
    logic            imm_br, imm_load;

    always_comb begin
        imm_res  = base_res;
        imm_br   = base_br;
        imm_load = 1'b1;
        if (is_mul) begin
            imm_res  = fast_res;
            imm_br   = 1'b0;
            imm_load = FAST_MUL;
        end else if (is_div) begin
            imm_br   = 1'b0;
            imm_load = div_zero | div_ovf;
            if (div_zero) imm_res = op[1] ? a  : '1;
            else          imm_res = op[1] ? '0 : a;
        end
    end

    // One shift-add / restoring step per cycle; the last step also applies signs.
    logic [2*XLEN-1:0] acc_nxt, prod_fin;
    logic [XLEN-1:0]   mul_fin, rem_nxt, quot_nxt, div_fin;
    logic [XLEN:0]     shl, diff;
    logic              q_bit, last;

    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
    assign prod_fin = neg_q ? -acc_nxt : acc_nxt;
    assign mul_fin  = sel_hi ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
    assign shl      = {rem, quot[XLEN-1]};
    assign diff     = shl - {1'b0, dvs};
    assign q_bit    = ~diff[XLEN];
    assign rem_nxt  = q_bit ? diff[XLEN-1:0] : shl[XLEN-1:0];
    assign quot_nxt = {quot[XLEN-2:0], q_bit};
    assign div_fin  = sel_hi ? (neg_r ? -rem_nxt : rem_nxt) : (neg_q ? -quot_nxt : quot_nxt);
    assign last     = (cnt == CW'(XLEN-1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quot   <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            sel_hi <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            // accept only happens in IDLE or in DONE with out_ready, so it overrides DONE->IDLE
            if (imm_load) begin
                state <= DONE;
                res_q <= imm_res;
                br_q  <= imm_br;
            end else begin
                state  <= is_mul ? MUL : DIV;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {{XLEN{1'b0}}, a_mag};
                mplier <= b_mag;
                rem    <= '0;
                quot   <= a_mag;
                dvs    <= b_mag;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                sel_hi <= is_mul ? (op[1:0] != 2'b00) : op[1];
            end
        end else begin
            case (state)
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        res_q <= mul_fin;
                        br_q  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                DIV: begin
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        res_q <= div_fin;
                        br_q  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                DONE:    if (bus.out_ready) state <= IDLE;
                default: ;
            endcase
        end
    end

    assign bus.result    = res_q;
    assign bus.br_mark   = br_q;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == MUL) | (state == DIV);
    assign bus.in_ready  = ~flush & ((state == IDLE) | ((state == DONE) & bus.out_ready));
endmodule

// File: tb/tb_alu_md_unit.sv
// Directed-vector bench for alu_md_unit: 32-bit iterative, 64-bit iterative
// and 32-bit single-cycle-multiply instances sharing one clock and reset.
module tb_alu_md_unit;
    localparam logic [4:0] OP_AND = 5'd0,  OP_ADD = 5'd2,  OP_SUB = 5'd3,  OP_XOR = 5'd4;
    localparam logic [4:0] OP_SLT = 5'd5,  OP_SLL = 5'd7,  OP_SRA = 5'd9,  OP_JUMP = 5'd10;
    localparam logic [4:0] OP_NOTEQ = 5'd11, OP_SGEU = 5'd13;
    localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;

    logic clk = 1'b0;
    logic rstn;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_md_unit_if #(.XLEN(32)) bus32 ();
    alu_md_unit_if #(.XLEN(64)) bus64 ();
    alu_md_unit_if #(.XLEN(32)) busf ();

    alu_md_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut32 (.clk(clk), .rstn(rstn), .flush(flush), .bus(bus32.slave));
    alu_md_unit #(.XLEN(64), .FAST_MUL(1'b0)) dut64 (.clk(clk), .rstn(rstn), .flush(flush), .bus(bus64.slave));
    alu_md_unit #(.XLEN(32), .FAST_MUL(1'b1)) dutf  (.clk(clk), .rstn(rstn), .flush(flush), .bus(busf.slave));

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic        br_mark;
        logic        busy;
        logic [63:0] result;
    } obs_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        br;
        logic [6:0]  lat;
    } vec_t;

    localparam vec_t V32 [0:20] = '{
        '{OP_ADD,    64'h7FFFFFFF, 64'h1,        64'h80000000, 1'b0, 7'd1},
        '{OP_NOTEQ,  64'h5,        64'h5,        64'h0,        1'b0, 7'd1},
        '{OP_JUMP,   64'h100,      64'h20,       64'h120,      1'b1, 7'd1},
        '{OP_SRA,    64'h80000000, 64'd36,       64'hF8000000, 1'b0, 7'd1},
        '{OP_SLT,    64'hFFFFFFFF, 64'h1,        64'h1,        1'b1, 7'd1},
        '{OP_SGEU,   64'h1,        64'hFFFFFFFF, 64'h1,        1'b0, 7'd1},
        '{OP_SUB,    64'h3,        64'h3,        64'h0,        1'b1, 7'd1},
        '{5'd14,     64'h5,        64'h6,        64'h0,        1'b0, 7'd1},
        '{OP_MULH,   64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0,        1'b0, 7'd33},
        '{OP_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 1'b0, 7'd33},
        '{OP_MUL,    64'h00010000, 64'h00010000, 64'h0,        1'b0, 7'd33},
        '{OP_MULHSU, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF, 1'b0, 7'd33},
        '{OP_MUL,    64'hFFFFFFFD, 64'h5,        64'hFFFFFFF1, 1'b0, 7'd33},
        '{OP_DIV,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 1'b0, 7'd33},
        '{OP_REM,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 1'b0, 7'd33},
        '{OP_DIVU,   64'h10,       64'h0,        64'hFFFFFFFF, 1'b0, 7'd1},
        '{OP_REMU,   64'h10,       64'h0,        64'h10,       1'b0, 7'd1},
        '{OP_DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1'b0, 7'd1},
        '{OP_REM,    64'h80000000, 64'hFFFFFFFF, 64'h0,        1'b0, 7'd1},
        '{OP_DIVU,   64'h80000000, 64'hFFFFFFFF, 64'h0,        1'b0, 7'd33},
        '{OP_REMU,   64'd100,      64'd7,        64'h2,        1'b0, 7'd33}
    };

    localparam vec_t V64 [0:3] = '{
        '{OP_SLL,  64'h1,                64'd63, 64'h8000000000000000, 1'b0, 7'd1},
        '{OP_DIVU, 64'hFFFFFFFFFFFFFFFF, 64'd3,  64'h5555555555555555, 1'b0, 7'd65},
        '{OP_DIV,  64'hFFFFFFFFFFFFFFF7, 64'd2,  64'hFFFFFFFFFFFFFFFC, 1'b0, 7'd65},
        '{OP_REM,  64'hFFFFFFFFFFFFFFF7, 64'd2,  64'hFFFFFFFFFFFFFFFF, 1'b0, 7'd65}
    };

    localparam vec_t VF [0:3] = '{
        '{OP_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 1'b0, 7'd1},
        '{OP_MULH,   64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0,        1'b0, 7'd1},
        '{OP_MULHSU, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF, 1'b0, 7'd1},
        '{OP_MUL,    64'hFFFFFFFD, 64'h5,        64'hFFFFFFF1, 1'b0, 7'd1}
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [4:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic ordy);
        case (s)
            0: begin
                bus32.in_valid = v; bus32.alu_op = op; bus32.op_a = a[31:0];
                bus32.op_b = b[31:0]; bus32.out_ready = ordy;
            end
            1: begin
                bus64.in_valid = v; bus64.alu_op = op; bus64.op_a = a;
                bus64.op_b = b; bus64.out_ready = ordy;
            end
            default: begin
                busf.in_valid = v; busf.alu_op = op; busf.op_a = a[31:0];
                busf.op_b = b[31:0]; busf.out_ready = ordy;
            end
        endcase
    endtask

    function automatic obs_t observe(input int s);
        obs_t o;
        case (s)
            0: o = '{bus32.in_ready, bus32.out_valid, bus32.br_mark, bus32.busy, {32'h0, bus32.result}};
            1: o = '{bus64.in_ready, bus64.out_valid, bus64.br_mark, bus64.busy, bus64.result};
            default: o = '{busf.in_ready, busf.out_valid, busf.br_mark, busf.busy, {32'h0, busf.result}};
        endcase
        return o;
    endfunction

    // Issue one op, scramble the operand inputs after accept, wait for out_valid, then consume.
    task automatic run(input int s, input string tag, input vec_t v);
        int   n  = 1;
        int   bc = 0;
        obs_t o;
        @(negedge clk);
        drive(s, 1'b1, v.op, v.a, v.b, 1'b0);
        #1 o = observe(s);
        check({tag, " in_ready"}, 64'(o.in_ready), 64'd1);
        @(negedge clk);
        drive(s, 1'b0, 5'd2, '1, '1, 1'b0);
        o = observe(s);
        while (!o.out_valid && n < 200) begin
            if (o.busy) bc++;
            @(negedge clk);
            n++;
            o = observe(s);
        end
        check({tag, " latency"}, 64'(n), 64'(v.lat));
        check({tag, " busy cycles"}, 64'(bc), (v.lat == 7'd1) ? 64'd0 : 64'(v.lat - 7'd1));
        check({tag, " result"}, o.result, v.res);
        check({tag, " br_mark"}, 64'(o.br_mark), 64'(v.br));
        drive(s, 1'b0, 5'd0, '0, '0, 1'b1);
        @(negedge clk);
        o = observe(s);
        check({tag, " drained"}, 64'(o.out_valid), 64'd0);
        drive(s, 1'b0, 5'd0, '0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int   cnt;
        rstn  = 1'b0;
        flush = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        o = observe(0);
        check("reset out_valid", 64'(o.out_valid), 64'd0);
        check("reset result", o.result, 64'd0);
        check("reset br_mark", 64'(o.br_mark), 64'd0);
        check("reset busy", 64'(o.busy), 64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 21; i++) run(0, $sformatf("x32[%0d]", i), V32[i]);

        // back-to-back base ops with out_ready held high
        @(negedge clk);
        drive(0, 1'b1, OP_ADD, 64'd1, 64'd2, 1'b1);
        #1 check("b2b rdy0", 64'(observe(0).in_ready), 64'd1);
        @(negedge clk);
        o = observe(0);
        check("b2b ov1", 64'(o.out_valid), 64'd1);
        check("b2b res1", o.result, 64'd3);
        drive(0, 1'b1, OP_SUB, 64'd10, 64'd4, 1'b1);
        #1 check("b2b rdy1", 64'(observe(0).in_ready), 64'd1);
        @(negedge clk);
        o = observe(0);
        check("b2b ov2", 64'(o.out_valid), 64'd1);
        check("b2b res2", o.result, 64'd6);
        drive(0, 1'b1, OP_XOR, 64'hF0, 64'hFF, 1'b1);
        @(negedge clk);
        o = observe(0);
        check("b2b ov3", 64'(o.out_valid), 64'd1);
        check("b2b res3", o.result, 64'h0F);
        drive(0, 1'b0, OP_AND, '0, '0, 1'b0);
        #1 check("b2b stall rdy", 64'(observe(0).in_ready), 64'd0);
        @(negedge clk);
        o = observe(0);
        check("b2b hold ov", 64'(o.out_valid), 64'd1);
        check("b2b hold res", o.result, 64'h0F);
        drive(0, 1'b0, OP_AND, '0, '0, 1'b1);
        @(negedge clk);
        check("b2b drained", 64'(observe(0).out_valid), 64'd0);
        drive(0, 1'b0, OP_AND, '0, '0, 1'b0);

        // flush in the tenth DIV cycle, with a competing request
        @(negedge clk);
        drive(0, 1'b1, OP_DIV, 64'd100, 64'd3, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, OP_AND, '0, '0, 1'b0);
        repeat (8) @(negedge clk);
        check("flush pre busy", 64'(observe(0).busy), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        drive(0, 1'b1, OP_ADD, 64'd1, 64'd1, 1'b0);
        #1 check("flush in_ready", 64'(observe(0).in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        drive(0, 1'b0, OP_AND, '0, '0, 1'b0);
        o = observe(0);
        check("flush out_valid", 64'(o.out_valid), 64'd0);
        check("flush busy", 64'(o.busy), 64'd0);
        check("flush result kept", o.result, 64'h0F);
        #1 check("flush idle rdy", 64'(observe(0).in_ready), 64'd1);
        cnt = 0;
        repeat (40) begin @(negedge clk); if (observe(0).out_valid) cnt++; end
        check("flush no result", 64'(cnt), 64'd0);

        // asynchronous reset mid-MUL
        @(negedge clk);
        drive(0, 1'b1, OP_MULHU, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, OP_AND, '0, '0, 1'b0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1 o = observe(0);
        check("rst mid-mul out_valid", 64'(o.out_valid), 64'd0);
        check("rst mid-mul busy", 64'(o.busy), 64'd0);
        check("rst mid-mul result", o.result, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        repeat (40) begin @(negedge clk); if (observe(0).out_valid) cnt++; end
        check("rst no result", 64'(cnt), 64'd0);
        check("rst idle rdy", 64'(observe(0).in_ready), 64'd1);

        for (int i = 0; i < 4; i++) run(1, $sformatf("x64[%0d]", i), V64[i]);
        for (int i = 0; i < 4; i++) run(2, $sformatf("fast[%0d]", i), VF[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
